// File: rtl/glip_scale_pkg.sv
// Shared helpers for the glip width converters (upscale and downscale).
package glip_scale_pkg;

  // Legal only when OUT is an exact 1x, 2x or 4x multiple of IN.
  function automatic bit ratio_ok(input int unsigned in_w, input int unsigned out_w);
    int unsigned r;
    if (in_w == 0) return 1'b0;
    if ((out_w % in_w) != 0) return 1'b0;
    r = out_w / in_w;
    return (r == 1) || (r == 2) || (r == 4);
  endfunction

endpackage

// File: rtl/glip_upscale.sv
// Narrow-to-wide FIFO width converter: gathers R slices, first slice lands in
// the most significant position of the output word.
module glip_upscale
  import glip_scale_pkg::*;
#(
  parameter int unsigned IN_SIZE  = 8,
  parameter int unsigned OUT_SIZE = IN_SIZE * 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IN_SIZE-1:0]  in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUT_SIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int unsigned RATIO = OUT_SIZE / IN_SIZE;

  if (!ratio_ok(IN_SIZE, OUT_SIZE)) begin : g_illegal
    $fatal(1, "glip_upscale: OUT_SIZE/IN_SIZE must be exactly 1, 2 or 4");
    assign in_ready  = 1'b0;
    assign out_valid = 1'b0;
    assign out_data  = '0;
  end else if (RATIO == 1) begin : g_pass
    assign out_data  = in_data;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
  end else begin : g_up
    localparam int unsigned CW = $clog2(RATIO);
    localparam int unsigned SW = (RATIO - 1) * IN_SIZE;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SW-1:0]       stage_q, stage_d;
    logic [OUT_SIZE-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                last, accept;

    // Only the final slice needs room in the output stage.
    assign last     = (cnt_q == LAST);
    assign in_ready = !last || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
      cnt_d       = cnt_q;
      stage_d     = stage_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      for (int unsigned k = 0; k < RATIO - 1; k++) begin
        if (accept && (cnt_q == CW'(k))) begin
          stage_d[(RATIO - 2 - k) * IN_SIZE +: IN_SIZE] = in_data;
        end
      end
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        if (last) begin
          cnt_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = {stage_q, in_data};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q       <= '0;
        out_data_q  <= '0;
        out_valid_q <= 1'b0;
      end else begin
        cnt_q       <= cnt_d;
        out_data_q  <= out_data_d;
        out_valid_q <= out_valid_d;
      end
    end

    // Staging is always fully overwritten before it reaches out_data.
    always_ff @(posedge clk) begin
      stage_q <= stage_d;
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
  end

endmodule

// File: tb/tb_glip_upscale.sv
// Bench for glip_upscale at 8->16 and 8->32: directed tables, reset corner
// case, and randomized handshakes against a slice-queue reference model.
module tb_glip_upscale;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid2, out_ready2, in_ready2, out_valid2;
  logic [7:0]  in_data2;
  logic [15:0] out_data2;
  logic        in_valid4, out_ready4, in_ready4, out_valid4;
  logic [7:0]  in_data4;
  logic [31:0] out_data4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  glip_upscale #(.IN_SIZE(8), .OUT_SIZE(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2)
  );

  glip_upscale #(.IN_SIZE(8), .OUT_SIZE(32)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4)
  );

  typedef struct packed {
    logic        iv;
    logic [7:0]  d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_od;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
    in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t          vecs [12];
  logic [7:0]    s4 [8];
  logic [31:0]   q [$];
  logic [31:0]   acc;
  int unsigned   pc;
  int unsigned   r;
  logic          iv, ordy, exp_ir, act_ir, act_ov;
  logic [7:0]    d;
  logic [31:0]   act_od;

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    chk("rst_ov2", 32'(out_valid2), 32'd0);
    chk("rst_od2", 32'(out_data2), 32'd0);
    chk("rst_ov4", 32'(out_valid4), 32'd0);
    chk("rst_od4", 32'(out_data4), 32'd0);
    do_reset();

    // 8->16: basic word, then held output with staging and drain+load
    vecs[0]  = '{1'b1, 8'hAB, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 8'hCD, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'hABCD};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 8'hAB, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[5]  = '{1'b1, 8'hCD, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[6]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 16'hABCD};
    vecs[7]  = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b1, 16'hABCD};
    vecs[8]  = '{1'b1, 8'h34, 1'b1, 1'b1, 1'b1, 16'hABCD};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'h1234};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'h1234};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid2 = vecs[i].iv; in_data2 = vecs[i].d; out_ready2 = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_ir", i), 32'(in_ready2), 32'(vecs[i].e_ir));
      chk($sformatf("vec%0d_ov", i), 32'(out_valid2), 32'(vecs[i].e_ov));
      if (vecs[i].e_ov) chk($sformatf("vec%0d_od", i), 32'(out_data2), 32'(vecs[i].e_od));
    end

    // 8->32: continuous stream, one word every 4 cycles, in_ready stays high
    s4[0] = 8'h11; s4[1] = 8'h22; s4[2] = 8'h33; s4[3] = 8'h44;
    s4[4] = 8'h55; s4[5] = 8'h66; s4[6] = 8'h77; s4[7] = 8'h88;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid4 = (i < 8); in_data4 = (i < 8) ? s4[i] : 8'h00; out_ready4 = 1'b1;
      #1;
      chk($sformatf("str%0d_ir", i), 32'(in_ready4), 32'd1);
      chk($sformatf("str%0d_ov", i), 32'(out_valid4), 32'((i == 4) || (i == 8)));
      if (i == 4) chk("str_w0", out_data4, 32'h11223344);
      if (i == 8) chk("str_w1", out_data4, 32'h55667788);
    end
    idle();

    // reset mid-word discards the partial slice
    @(negedge clk);
    in_valid2 = 1'b1; in_data2 = 8'hAB; out_ready2 = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid2 = 1'b0;
    #1;
    chk("rstmid_ov", 32'(out_valid2), 32'd0);
    chk("rstmid_od", 32'(out_data2), 32'd0);
    @(negedge clk);
    chk("rstmid_ov_b", 32'(out_valid2), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b1; in_data2 = 8'hCD;
    @(negedge clk);
    in_data2 = 8'hEF;
    @(negedge clk);
    in_valid2 = 1'b0;
    #1;
    chk("rstmid_ov_w", 32'(out_valid2), 32'd1);
    chk("rstmid_od_w", 32'(out_data2), 32'h0000CDEF);

    // randomized handshakes against a queue model of assembled words
    for (int k = 0; k < 2; k++) begin
      r = (k == 0) ? 2 : 4;
      q.delete();
      acc = '0;
      pc = 0;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
        @(negedge clk);
        iv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 3) != 0);
        d    = 8'($urandom);
        if (k == 0) begin
          in_valid2 = iv; in_data2 = d; out_ready2 = ordy;
        end else begin
          in_valid4 = iv; in_data4 = d; out_ready4 = ordy;
        end
        #1;
        act_ir = (k == 0) ? in_ready2 : in_ready4;
        act_ov = (k == 0) ? out_valid2 : out_valid4;
        act_od = (k == 0) ? 32'(out_data2) : out_data4;
        exp_ir = !((pc == r - 1) && (q.size() != 0) && !ordy);
        chk($sformatf("rnd%0d_ir", r), 32'(act_ir), 32'(exp_ir));
        chk($sformatf("rnd%0d_ov", r), 32'(act_ov), 32'(q.size() != 0));
        if (q.size() != 0) chk($sformatf("rnd%0d_od", r), act_od, q[0]);
        if ((q.size() != 0) && ordy) void'(q.pop_front());
        if (iv && exp_ir) begin
          acc = (acc << 8) | 32'(d);
          pc++;
          if (pc == r) begin
            q.push_back(acc);
            acc = '0;
            pc = 0;
          end
        end
      end
      idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
